// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Issue stage in front of a combinational ALU. A small register file supplies
// the operands. Each accepted command goes through three states:
// IDLE (accept), EXEC (capture the ALU result and write it back), and
// RESP (hold the response until it is consumed).
// Only one command is in flight at a time, so no hazard logic is needed.
// Optional feature: define ALU_SEQ_STICKY_CARRY_EN to get a sticky carry flag.
// When it is not defined, sticky_c is tied low and no flop is built for it.

module alu_op_sequencer #(
    parameter int WIDTH = 6,
    parameter int REGS  = 4,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             cmd_imm,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry,
    output logic             resp_zero,
    output logic             sticky_c
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             cmd_ready_q;
    logic [3:0]       alu_ctrl_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [AW-1:0]    rd_q;
    logic             resp_valid_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_carry_q;
    logic             resp_zero_q;
    logic [WIDTH-1:0] rf_q [REGS];

    logic             accept_d;
    logic             capture_d;
    logic [WIDTH-1:0] operand_a_d;
    logic [WIDTH-1:0] operand_b_d;

    // Operand selection and handshake qualifiers. Reads in IDLE see every
    // earlier writeback, because the write happens in EXEC, which is before
    // the next IDLE.
    always_comb begin
        accept_d    = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
        capture_d   = (state_q == ST_EXEC);
        operand_a_d = rf_q[cmd_rs1];
        operand_b_d = cmd_imm ? cmd_data : rf_q[cmd_rs2];
    end

    // Register file: clears on reset and is written once per command in EXEC.
    // Reset wins over capture, so a command that is interrupted never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (capture_d) begin
            for (int i = 0; i < REGS; i++) begin
                if (rd_q == AW'(i)) begin
                    rf_q[i] <= alu_out;
                end
            end
        end
    end

    // Sequencing FSM. All outputs are registered and updated together with
    // the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            alu_ctrl_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rd_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
            resp_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        // The old register values become the operands, even
                        // when rd names one of the sources.
                        alu_ctrl_q  <= cmd_op;
                        alu_a_q     <= operand_a_d;
                        alu_b_q     <= operand_b_d;
                        rd_q        <= cmd_rd;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_data_q  <= alu_out;
                    resp_carry_q <= alu_carry;
                    resp_zero_q  <= alu_zero;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    // The response stays frozen until the consumer takes it.
                    // A command is only accepted on a later cycle.
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        cmd_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    cmd_ready_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STICKY_CARRY_EN
    logic sticky_q;

    // Sticky carry: an accepted op 1111 clears it, and any carry seen at
    // capture sets it. Accept and capture are in different states, so they
    // never happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (accept_d && (cmd_op == 4'b1111)) begin
            sticky_q <= 1'b0;
        end else if (capture_d && alu_carry) begin
            sticky_q <= 1'b1;
        end
    end

    assign sticky_c = sticky_q;
`else
    assign sticky_c = 1'b0;
`endif

    assign cmd_ready  = cmd_ready_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_carry = resp_carry_q;
    assign resp_zero  = resp_zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. It models the external ALU and keeps a
// reference register file. The test has three parts: a table of directed
// vectors, reset and back-pressure corner cases, and randomized commands.
// Building with ALU_SEQ_STICKY_CARRY_EN defined enables the sticky
// expectations.

module tb_alu_op_sequencer;

`ifdef ALU_SEQ_STICKY_CARRY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic       cmd_imm = 1'b0;
    logic [5:0] cmd_data = '0;
    logic [3:0] alu_ctrl;
    logic [5:0] alu_a, alu_b, alu_out;
    logic       alu_carry, alu_zero;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [5:0] resp_data;
    logic       resp_carry, resp_zero, sticky_c;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    int ref_rf [4];
    bit ref_sticky;

    always #5 clk = ~clk;

    // ALU behaviour: AND 0000, OR 0001, ADD 0010, XOR 0100, SUB 0110,
    // SLT 1000. Any other code gives 0.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b);
        int ai, bi, r, sa, sb;
        bit c;
        ai = int'(a);
        bi = int'(b);
        r = 0;
        c = 1'b0;
        case (op)
            4'b0000: r = int'(a & b);
            4'b0001: r = int'(a | b);
            4'b0010: begin r = (ai + bi) % 64; c = (ai + bi) > 63; end
            4'b0100: r = int'(a ^ b);
            4'b0110: begin r = (ai - bi + 64) % 64; c = ai < bi; end
            4'b1000: begin
                sa = (ai >= 32) ? ai - 64 : ai;
                sb = (bi >= 32) ? bi - 64 : bi;
                r = (sa < sb) ? 1 : 0;
            end
            default: r = 0;
        endcase
        return {c, (r == 0), r[5:0]};
    endfunction

    assign {alu_carry, alu_zero, alu_out} = alu_fn(alu_ctrl, alu_a, alu_b);

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .cmd_data(cmd_data),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_carry(resp_carry), .resp_zero(resp_zero),
        .sticky_c(sticky_c)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_rf[i] = 0;
        ref_sticky = 1'b0;
    endtask

    // Runs one complete command. It starts and ends at a falling edge with
    // the DUT idle. While the response is held back for 'hold' cycles,
    // cmd_valid is driven with junk that must be ignored.
    task automatic run_cmd(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                           input bit imm, input int data, input int hold,
                           output int got_data, output int got_c, output int got_z);
        logic [5:0] a, b;
        logic [7:0] res;
        bit sticky_acc;
        a = 6'(ref_rf[rs1]);
        b = imm ? 6'(data) : 6'(ref_rf[rs2]);
        res = alu_fn(op, a, b);
        sticky_acc = STICKY_EN && (op != 4'b1111) && ref_sticky;

        chk("idle_cmd_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = 2'(rd); cmd_rs1 = 2'(rs1);
        cmd_rs2 = 2'(rs2); cmd_imm = imm; cmd_data = 6'(data);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("exec_cmd_ready", int'(cmd_ready), 0);
        chk("exec_resp_valid", int'(resp_valid), 0);
        chk("exec_alu_ctrl", int'(alu_ctrl), int'(op));
        chk("exec_alu_a", int'(alu_a), int'(a));
        chk("exec_alu_b", int'(alu_b), int'(b));
        chk("exec_sticky", int'(sticky_c), int'(sticky_acc));
        @(posedge clk);
        @(negedge clk);
        ref_rf[rd] = int'(res[5:0]);
        ref_sticky = STICKY_EN && (sticky_acc || res[7]);
        got_data = int'(resp_data);
        got_c = int'(resp_carry);
        got_z = int'(resp_zero);
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", int'(resp_valid), 1);
            chk("resp_data", int'(resp_data), int'(res[5:0]));
            chk("resp_carry", int'(resp_carry), int'(res[7]));
            chk("resp_zero", int'(resp_zero), int'(res[6]));
            chk("resp_cmd_ready", int'(cmd_ready), 0);
            chk("resp_sticky", int'(sticky_c), int'(ref_sticky));
            if (h < hold) begin
                cmd_valid = 1'b1; cmd_op = 4'($urandom); cmd_rd = 2'($urandom);
                cmd_rs1 = 2'($urandom); cmd_imm = 1'b1; cmd_data = 6'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_resp_valid", int'(resp_valid), 0);
        chk("post_cmd_ready", int'(cmd_ready), 1);
        txn++;
        $display("txn %0d op=%b rd=%0d a=%0d b=%0d hold=%0d -> data=%0d c=%0d z=%0d sticky=%0d",
                 txn, op, rd, a, b, hold, got_data, got_c, got_z, sticky_c);
    endtask

    typedef struct {
        logic [3:0] op;
        int rd, rs1, rs2;
        bit imm;
        int data, hold;
        int exp_data, exp_c, exp_z;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gd, gc, gz;
        logic [3:0] ops [7];
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0100;
        ops[4] = 4'b0110; ops[5] = 4'b1000; ops[6] = 4'b1111;

        //          op       rd rs1 rs2 imm data hold  data c z
        vecs[0] = '{4'b0001, 1, 0, 0, 1'b1, 5, 0,  5, 0, 0};
        vecs[1] = '{4'b0001, 2, 0, 0, 1'b1, 3, 0,  3, 0, 0};
        vecs[2] = '{4'b0010, 3, 1, 2, 1'b0, 0, 0,  8, 0, 0};
        vecs[3] = '{4'b0110, 0, 2, 1, 1'b0, 0, 5, 62, 1, 0};
        vecs[4] = '{4'b1000, 0, 1, 2, 1'b0, 0, 0,  0, 0, 1};
        vecs[5] = '{4'b0100, 3, 3, 0, 1'b1, 8, 0,  0, 0, 1};
        vecs[6] = '{4'b0000, 1, 1, 0, 1'b1, 0, 0,  0, 0, 1};

        // Reset and check the reset values.
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_alu_ctrl", int'(alu_ctrl), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_resp_data", int'(resp_data), 0);
        chk("rst_resp_carry", int'(resp_carry), 0);
        chk("rst_resp_zero", int'(resp_zero), 0);
        chk("rst_sticky", int'(sticky_c), 0);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            run_cmd(vecs[v].op, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].imm,
                    vecs[v].data, vecs[v].hold, gd, gc, gz);
            chk($sformatf("vec%0d_data", v), gd, vecs[v].exp_data);
            chk($sformatf("vec%0d_carry", v), gc, vecs[v].exp_c);
            chk($sformatf("vec%0d_zero", v), gz, vecs[v].exp_z);
        end

        // Reset during the EXEC cycle of ADD r3 = r2 + r2.
        cmd_valid = 1'b1; cmd_op = 4'b0010; cmd_rd = 2'd3; cmd_rs1 = 2'd2;
        cmd_rs2 = 2'd2; cmd_imm = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rstexec_resp_valid", int'(resp_valid), 0);
        chk("rstexec_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        chk("rstexec_resp_valid2", int'(resp_valid), 0);
        run_cmd(4'b0001, 0, 3, 0, 1'b1, 0, 0, gd, gc, gz);
        chk("rstexec_r3_zero", gd, 0);

        // Sticky carry: 63 + 1 sets it, it survives another op, and 1111
        // clears it.
        run_cmd(4'b0001, 0, 0, 0, 1'b1, 63, 0, gd, gc, gz);
        run_cmd(4'b0010, 1, 0, 0, 1'b1, 1, 0, gd, gc, gz);
        chk("add63_carry", gc, 1);
        chk("add63_sticky", int'(sticky_c), int'(STICKY_EN));
        run_cmd(4'b0100, 2, 0, 0, 1'b1, 1, 2, gd, gc, gz);
        chk("sticky_persist", int'(sticky_c), int'(STICKY_EN));
        run_cmd(4'b1111, 3, 0, 0, 1'b1, 9, 0, gd, gc, gz);
        chk("op1111_data", gd, 0);
        chk("op1111_sticky", int'(sticky_c), 0);

        // Randomized commands checked against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
            run_cmd(rop, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 2)), gd, gc, gz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
